sdram_wide_responder: RTL and testbench

// - Responder end of the arbiter's 128-bit SDRAM request bus (addr/be/read/write/wrdata -> ac/rddata).
// - Splits each 128-bit word access into 16-bit beats on an Avalon-MM master port to the SDRAM controller.
// - Reassembles read beats and returns a one-cycle acknowledge to the requester.
// - Sits between the SDRAM arbiter and the SDRAM controller, in place of a direct controller hookup.

---
 rtl/sdram_bus_pkg.sv | 38 +++
 rtl/sdram_beat_assembler.sv | 43 ++++
 rtl/sdram_wide_responder.sv | 172 +++++++++++++++++
 tb/tb_sdram_wide_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_bus_pkg.sv
// Shared geometry, FSM state type and beat-selection helper for the wide SDRAM responder.
package sdram_bus_pkg;

    localparam int BEATS      = 8;
    localparam int ADDR_W     = 22;
    localparam int AVM_ADDR_W = 25;
    localparam int WORD_W     = 128;
    localparam int BEAT_W     = 16;
    localparam int BE_W       = WORD_W / 8;
    localparam int BEAT_BE_W  = BEAT_W / 8;
    localparam int IDX_W      = $clog2(BEATS);
    // One extra bit so a beat index can also express "past the last beat".
    localparam int CNT_W      = IDX_W + 1;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_BEAT,
        ST_RD_ISSUE,
        ST_RD_DRAIN,
        ST_ACK
    } state_e;

    // Lowest beat index >= start with any byte lane enabled; BEATS when none remain.
    function automatic logic [CNT_W-1:0] next_beat(input logic [BE_W-1:0]  be,
                                                   input logic [CNT_W-1:0] start);
        logic [CNT_W-1:0] res;
        res = CNT_W'(BEATS);
        for (int i = BEATS - 1; i >= 0; i--) begin
            if (CNT_W'(i) >= start && be[i*BEAT_BE_W +: BEAT_BE_W] != '0) begin
                res = CNT_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sdram_beat_assembler.sv
// Collects in-order 16-bit read beats into a 128-bit word; publishes the word
// and a done pulse when the final beat of the word arrives.
module sdram_beat_assembler
    import sdram_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              beat_valid_i,
    input  logic [BEAT_W-1:0] beat_data_i,
    output logic              done_o,
    output logic [WORD_W-1:0] word_o
);

    logic [IDX_W-1:0] ret_cnt_q;
    word_t            buf_q;
    word_t            buf_d;
    word_t            word_q;

    assign done_o = beat_valid_i && (ret_cnt_q == IDX_W'(BEATS - 1));
    assign word_o = word_q;

    // Place the incoming beat into its lane of the partially built word.
    always_comb begin
        buf_d = buf_q;
        buf_d[ret_cnt_q*BEAT_W +: BEAT_W] = beat_data_i;
    end

    // Count returns and publish the whole word only once it is complete.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_cnt_q <= '0;
            buf_q     <= '0;
            word_q    <= '0;
        end else if (beat_valid_i) begin
            buf_q     <= buf_d;
            ret_cnt_q <= done_o ? '0 : ret_cnt_q + IDX_W'(1);
            if (done_o) begin
                word_q <= buf_d;
            end
        end
    end

endmodule

// File: rtl/sdram_wide_responder.sv
// Responder for the 128-bit SDRAM request bus: splits each word access into
// 16-bit Avalon-MM beats and returns a one-cycle acknowledge.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | sample and latch request; write has priority over read
// ST_WR_BEAT  | drive one enabled write beat until accepted, skip empty beats
// ST_RD_ISSUE | issue read beats 0..7, throttled by the pending limit
// ST_RD_DRAIN | all reads issued, wait for the remaining returns
// ST_ACK      | ar_ac high for this single cycle
module sdram_wide_responder
    import sdram_bus_pkg::*;
#(
    parameter int MAX_PENDING = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     ar_addr,
    input  logic [BE_W-1:0]       ar_be,
    input  logic                  ar_read,
    input  logic                  ar_write,
    input  logic [WORD_W-1:0]     ar_wrdata,
    output logic                  ar_ac,
    output logic [WORD_W-1:0]     ar_rddata,
    output logic [AVM_ADDR_W-1:0] avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [BEAT_W-1:0]     avm_writedata,
    output logic [BEAT_BE_W-1:0]  avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [BEAT_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid
);

    localparam logic [CNT_W-1:0] NO_BEAT  = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);

    state_e                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [BE_W-1:0]         be_q;
    word_t                   wrdata_q;
    logic [CNT_W-1:0]        beat_q;
    logic [CNT_W-1:0]        pending_q;
    logic                    ar_ac_q;
    logic [AVM_ADDR_W-1:0]   avm_address_q;
    logic                    avm_read_q;
    logic                    avm_write_q;
    logic [BEAT_W-1:0]       avm_writedata_q;
    logic [BEAT_BE_W-1:0]    avm_byteenable_q;

    logic                    rd_phase;
    logic                    beat_ret;
    logic                    rd_fire;
    logic [CNT_W-1:0]        first_beat_d;
    logic [CNT_W-1:0]        cont_beat_d;
    logic [CNT_W-1:0]        issued_d;
    logic [CNT_W-1:0]        pending_d;
    logic                    asm_done;

    // Returns outside a read (e.g. left over from before a reset) never reach the assembler.
    assign rd_phase     = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_DRAIN);
    assign beat_ret     = rd_phase && avm_readdatavalid;
    assign rd_fire      = avm_read_q && !avm_waitrequest;
    assign first_beat_d = next_beat(ar_be, '0);
    assign cont_beat_d  = next_beat(be_q, beat_q + CNT_W'(1));
    assign issued_d     = beat_q + CNT_W'(rd_fire);
    assign pending_d    = pending_q + CNT_W'(rd_fire) - CNT_W'(beat_ret);

    sdram_beat_assembler u_asm (
        .clk          (clk),
        .reset_n      (reset_n),
        .beat_valid_i (beat_ret),
        .beat_data_i  (avm_readdata),
        .done_o       (asm_done),
        .word_o       (ar_rddata)
    );

    // Request sequencing with all Avalon command outputs and ar_ac registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            addr_q           <= '0;
            be_q             <= '0;
            wrdata_q         <= '0;
            beat_q           <= '0;
            pending_q        <= '0;
            ar_ac_q          <= 1'b0;
            avm_address_q    <= '0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_writedata_q  <= '0;
            avm_byteenable_q <= '0;
        end else begin
            ar_ac_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    addr_q   <= ar_addr;
                    be_q     <= ar_be;
                    wrdata_q <= ar_wrdata;
                    beat_q   <= '0;
                    if (ar_write) begin
                        if (first_beat_d == NO_BEAT) begin
                            state_q <= ST_ACK;
                            ar_ac_q <= 1'b1;
                        end else begin
                            state_q          <= ST_WR_BEAT;
                            beat_q           <= first_beat_d;
                            avm_write_q      <= 1'b1;
                            avm_address_q    <= {ar_addr, first_beat_d[IDX_W-1:0]};
                            avm_writedata_q  <= ar_wrdata[first_beat_d[IDX_W-1:0]*BEAT_W +: BEAT_W];
                            avm_byteenable_q <= ar_be[first_beat_d[IDX_W-1:0]*BEAT_BE_W +: BEAT_BE_W];
                        end
                    end else if (ar_read) begin
                        state_q          <= ST_RD_ISSUE;
                        avm_read_q       <= 1'b1;
                        avm_address_q    <= {ar_addr, IDX_W'(0)};
                        avm_byteenable_q <= '1;
                    end
                end
                ST_WR_BEAT: begin
                    if (!avm_waitrequest) begin
                        if (cont_beat_d == NO_BEAT) begin
                            avm_write_q <= 1'b0;
                            state_q     <= ST_ACK;
                            ar_ac_q     <= 1'b1;
                        end else begin
                            beat_q           <= cont_beat_d;
                            avm_address_q    <= {addr_q, cont_beat_d[IDX_W-1:0]};
                            avm_writedata_q  <= wrdata_q[cont_beat_d[IDX_W-1:0]*BEAT_W +: BEAT_W];
                            avm_byteenable_q <= be_q[cont_beat_d[IDX_W-1:0]*BEAT_BE_W +: BEAT_BE_W];
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    pending_q <= pending_d;
                    beat_q    <= issued_d;
                    if (rd_fire) begin
                        avm_address_q <= {addr_q, issued_d[IDX_W-1:0]};
                    end
                    if (issued_d == NO_BEAT) begin
                        avm_read_q <= 1'b0;
                        state_q    <= ST_RD_DRAIN;
                    end else begin
                        // Present the next read only if it cannot push pending past the limit.
                        avm_read_q <= (pending_d < PEND_MAX);
                    end
                end
                ST_RD_DRAIN: begin
                    pending_q <= pending_d;
                    if (asm_done) begin
                        state_q <= ST_ACK;
                        ar_ac_q <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ar_ac          = ar_ac_q;
    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = avm_byteenable_q;

endmodule

// File: tb/tb_sdram_wide_responder.sv
// Scoreboard bench: a word-level reference memory predicts Avalon write beats and
// read words; an Avalon slave model with its own halfword memory serves the DUT.
module tb_sdram_wide_responder;

    localparam int MAXP = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [21:0]  ar_addr;
    logic [15:0]  ar_be;
    logic         ar_read;
    logic         ar_write;
    logic [127:0] ar_wrdata;
    logic         ar_ac;
    logic [127:0] ar_rddata;
    logic [24:0]  avm_address;
    logic         avm_read;
    logic         avm_write;
    logic [15:0]  avm_writedata;
    logic [1:0]   avm_byteenable;
    logic         avm_waitrequest;
    logic [15:0]  avm_readdata;
    logic         avm_readdatavalid;

    sdram_wide_responder #(.MAX_PENDING(MAXP)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ar_addr           (ar_addr),
        .ar_be             (ar_be),
        .ar_read           (ar_read),
        .ar_write          (ar_write),
        .ar_wrdata         (ar_wrdata),
        .ar_ac             (ar_ac),
        .ar_rddata         (ar_rddata),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    typedef struct { bit rd; logic [127:0] data; }               ack_t;
    typedef struct { logic [24:0] a; logic [15:0] d; logic [1:0] be; } wr_t;
    typedef struct { int due; logic [15:0] d; }                   rd_t;

    ack_t ack_exp[$];
    wr_t  wr_exp[$];
    rd_t  rdq[$];

    logic [15:0]  smem [logic [24:0]];
    logic [127:0] rmem [logic [21:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 3;
    int last_valid_cyc = -100;
    int out_cnt = 0;
    int rd_acc = 0;
    int wr_acc = 0;
    bit wr_rand = 1'b0;
    logic [127:0] last_rd = '0;

    function automatic logic [15:0] fill(input logic [24:0] a);
        return a[15:0] ^ {a[24:16], 7'h35};
    endfunction

    function automatic logic [15:0] srd(input logic [24:0] a);
        return smem.exists(a) ? smem[a] : fill(a);
    endfunction

    function automatic logic [127:0] ref_word(input logic [21:0] a);
        logic [127:0] w;
        if (rmem.exists(a)) return rmem[a];
        for (int k = 0; k < 8; k++) w[16*k +: 16] = fill({a, 3'(k)});
        return w;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_ar_ac"},          128'(ar_ac),          '0);
        chk({tag, "_ar_rddata"},      ar_rddata,            '0);
        chk({tag, "_avm_read"},       128'(avm_read),       '0);
        chk({tag, "_avm_write"},      128'(avm_write),      '0);
        chk({tag, "_avm_address"},    128'(avm_address),    '0);
        chk({tag, "_avm_writedata"},  128'(avm_writedata),  '0);
        chk({tag, "_avm_byteenable"}, 128'(avm_byteenable), '0);
    endtask

    // Issue one request, predict its effects, wait (bounded) for ar_ac; n = cycles to ack.
    task automatic do_op(input bit rd, input bit wr, input logic [21:0] a, input logic [15:0] be,
                         input logic [127:0] d, output int n);
        int rd0, wr0, nw;
        bit got;
        logic [127:0] m, old;
        ack_t e;
        wr_t  w;
        nw = 0;
        if (wr) begin
            old = ref_word(a);
            for (int k = 0; k < 16; k++) m[8*k +: 8] = {8{be[k]}};
            rmem[a] = (old & ~m) | (d & m);
            for (int k = 0; k < 8; k++) begin
                if (be[2*k +: 2] != 2'b00) begin
                    w.a = {a, 3'(k)}; w.d = d[16*k +: 16]; w.be = be[2*k +: 2];
                    wr_exp.push_back(w);
                    nw++;
                end
            end
            e.rd = 1'b0; e.data = '0;
        end else begin
            e.rd = 1'b1; e.data = ref_word(a);
        end
        ack_exp.push_back(e);
        rd0 = rd_acc; wr0 = wr_acc;
        ar_addr = a; ar_be = be; ar_wrdata = d; ar_read = rd; ar_write = wr;
        n = 0; got = 1'b0;
        while (!got && n < 300) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (ar_ac) got = 1'b1;
            else if (n == 1) begin
                ar_addr = 22'($urandom); ar_be = 16'($urandom); ar_wrdata = {4{$urandom}};
            end
        end
        ar_read = 1'b0; ar_write = 1'b0;
        chk("ack_received", 128'(got), 1);
        @(posedge clk); #1;
        chk("op_avm_reads",  128'(rd_acc - rd0), wr ? 128'd0 : 128'd8);
        chk("op_avm_writes", 128'(wr_acc - wr0), 128'(nw));
    endtask

    // Avalon slave: accepts commands at negedge, drives responses just after posedge.
    initial begin : slave
        rd_t r;
        wr_t w;
        logic [15:0] cur;
        int due;
        bit acc_rd;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(negedge clk);
            if (avm_write && !avm_waitrequest) begin
                wr_acc++;
                chk("avm_write_expected", 128'(wr_exp.size() > 0), 1);
                if (wr_exp.size() > 0) begin
                    w = wr_exp.pop_front();
                    chk("avm_write_address", 128'(avm_address),    128'(w.a));
                    chk("avm_writedata",     128'(avm_writedata),  128'(w.d));
                    chk("avm_byteenable",    128'(avm_byteenable), 128'(w.be));
                end
                cur = srd(avm_address);
                if (avm_byteenable[0]) cur[7:0]  = avm_writedata[7:0];
                if (avm_byteenable[1]) cur[15:8] = avm_writedata[15:8];
                smem[avm_address] = cur;
            end
            acc_rd = avm_read && !avm_waitrequest;
            if (acc_rd) begin
                rd_acc++;
                due = cyc + lat;
                if (rdq.size() > 0 && rdq[$].due >= due) due = rdq[$].due + 1;
                r.due = due; r.d = srd(avm_address);
                rdq.push_back(r);
                out_cnt++;
            end
            if (avm_readdatavalid) out_cnt--;
            if (acc_rd) chk("pending_bound", 128'(out_cnt <= MAXP), 1);
            @(posedge clk); #1;
            cyc++;
            avm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rdq.size() > 0 && rdq[0].due <= cyc) begin
                r = rdq.pop_front();
                avm_readdatavalid = 1'b1; avm_readdata = r.d; last_valid_cyc = cyc;
            end else begin
                avm_readdatavalid = 1'b0; avm_readdata = 16'($urandom);
            end
        end
    end

    // Acknowledge monitor: pops the prediction for every ar_ac pulse.
    initial begin : monitor
        ack_t e;
        forever begin
            @(negedge clk);
            if (ar_ac === 1'b1) begin
                chk("ack_expected", 128'(ack_exp.size() > 0), 1);
                if (ack_exp.size() > 0) begin
                    e = ack_exp.pop_front();
                    if (e.rd) begin
                        chk("rd_word", ar_rddata, e.data);
                        chk("rd_ack_latency", 128'(cyc - last_valid_cyc), 1);
                        last_rd = e.data;
                    end else begin
                        chk("wr_rddata_hold", ar_rddata, last_rd);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int op;
        logic [15:0]  be;
        logic [21:0]  a;
        logic [127:0] pattern;
        reset_n = 1'b0;
        ar_addr = '0; ar_be = '0; ar_read = 1'b0; ar_write = 1'b0; ar_wrdata = '0;
        pattern = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        for (int k = 0; k < 8; k++) smem[{22'h000123, 3'(k)}] = 16'(k);
        rmem[22'h000123] = pattern;

        repeat (3) @(posedge clk);
        #1;
        chk_quiet_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_op(1'b0, 1'b1, 22'h000010, 16'hFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, n);
        chk("wr_full_latency", 128'(n), 9);
        do_op(1'b0, 1'b1, 22'h000011, 16'h0003, 128'hDEAD_BEEF_CAFE_F00D_1111_2222_3333_4444, n);
        chk("wr_one_beat_latency", 128'(n), 2);
        do_op(1'b0, 1'b1, 22'h000012, 16'h0000, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, n);
        chk("wr_no_beat_latency", 128'(n), 1);

        lat = 3;
        do_op(1'b1, 1'b0, 22'h000123, 16'h0000, '0, n);
        chk("rd_index_word", ar_rddata, pattern);

        do_op(1'b1, 1'b1, 22'h000013, 16'hF0F0, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0, n);

        // Reset in the middle of a read; its returns then arrive while idle.
        ar_addr = 22'h000123; ar_read = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        reset_n = 1'b0; ar_read = 1'b0;
        #1;
        chk_quiet_outputs("midread_reset");
        last_rd = '0;
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("stale_rddata", ar_rddata, '0);
        chk("stale_drained", 128'(rdq.size()), 0);

        do_op(1'b1, 1'b0, 22'h000010, 16'h0000, '0, n);
        do_op(1'b1, 1'b0, 22'h000011, 16'h0000, '0, n);
        do_op(1'b1, 1'b0, 22'h000013, 16'h0000, '0, n);

        wr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(0, 2);
            lat = $urandom_range(1, 4);
            a   = 22'h2A0000 | 22'($urandom_range(0, 7));
            be  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) be = be & 16'h0F0F;
            do_op(op != 1, op != 0, a, be, {$urandom, $urandom, $urandom, $urandom}, n);
        end
        wr_rand = 1'b0;

        repeat (20) @(posedge clk);
        #1;
        chk("wr_queue_empty",  128'(wr_exp.size()),  0);
        chk("ack_queue_empty", 128'(ack_exp.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
